// File: rtl/led_breathe.sv
// PWM breathing LED driver: ramp up, hold high, ramp down, hold low, repeat while en.
// Optional GAMMA_EN: drive the PWM comparator with (duty*duty)>>PWM_BITS instead of raw duty.
module led_breathe #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 105469,
    parameter int HOLD_STEPS = 64
) (
    input  logic                clk27m,
    input  logic                rst,
    input  logic                en,
    output logic                led_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                cycle_done
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PWM_BITS-1:0] MAX_M1     = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] ONE        = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]       PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0]       HOLD_LAST  = HW'(HOLD_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_HOLD_HI,
        S_RAMP_DOWN,
        S_HOLD_LO
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
    logic [HW-1:0]       r_hold, w_hold_nxt;
    logic [PW-1:0]       r_presc;
    logic [PWM_BITS-1:0] r_pwm;
    logic                r_led;
    logic                r_done, w_done_nxt;
    logic                w_tick;
    logic                w_presc_clr;
    logic [PWM_BITS-1:0] w_duty_eff;

    assign w_tick = (r_presc == PRESC_LAST);

`ifdef GAMMA_EN
    logic [2*PWM_BITS-1:0] w_sq;
    assign w_sq       = (2*PWM_BITS)'(r_duty) * (2*PWM_BITS)'(r_duty);
    assign w_duty_eff = w_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign w_duty_eff = r_duty;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_hold_nxt  = r_hold;
        w_done_nxt  = 1'b0;
        w_presc_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_duty_nxt = '0;
                if (en) begin
                    w_state_nxt = S_RAMP_UP;
                    w_presc_clr = 1'b1;
                end
            end
            S_RAMP_UP: begin
                if (w_tick) begin
                    w_duty_nxt = r_duty + ONE;
                    if (r_duty == MAX_M1) begin
                        w_state_nxt = S_HOLD_HI;
                        w_hold_nxt  = '0;
                    end
                end
            end
            S_HOLD_HI: begin
                if (w_tick) begin
                    if (r_hold == HOLD_LAST) begin
                        w_state_nxt = S_RAMP_DOWN;
                    end else begin
                        w_hold_nxt = r_hold + HW'(1);
                    end
                end
            end
            S_RAMP_DOWN: begin
                if (w_tick) begin
                    w_duty_nxt = r_duty - ONE;
                    if (r_duty == ONE) begin
                        w_state_nxt = S_HOLD_LO;
                        w_hold_nxt  = '0;
                    end
                end
            end
            S_HOLD_LO: begin
                if (w_tick) begin
                    if (r_hold == HOLD_LAST) begin
                        // Prescaler keeps running so back-to-back breaths stay on one tick grid.
                        w_done_nxt  = 1'b1;
                        w_state_nxt = en ? S_RAMP_UP : S_IDLE;
                    end else begin
                        w_hold_nxt = r_hold + HW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_duty_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk27m) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_duty  <= '0;
            r_hold  <= '0;
            r_presc <= '0;
            r_pwm   <= '0;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_hold  <= w_hold_nxt;
            r_presc <= (w_presc_clr || w_tick) ? '0 : r_presc + PW'(1);
            r_pwm   <= r_pwm + ONE;
            r_led   <= (r_pwm < w_duty_eff);
            r_done  <= w_done_nxt;
        end
    end

    assign led_out    = r_led;
    assign duty       = r_duty;
    assign cycle_done = r_done;

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe with PWM_BITS=4, STEP_DIV=4 (HOLD_STEPS=2 main, 8 for PWM ratio).
// Cycle k = k-th falling edge after the rising edge that enters RAMP_UP.
module tb_led_breathe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       en8 = 1'b0;
    logic       led, done, led8, done8;
    logic [3:0] duty, duty8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_breathe #(.PWM_BITS(4), .STEP_DIV(4), .HOLD_STEPS(2)) u_dut (
        .clk27m(clk), .rst(rst), .en(en),
        .led_out(led), .duty(duty), .cycle_done(done)
    );

    led_breathe #(.PWM_BITS(4), .STEP_DIV(4), .HOLD_STEPS(8)) u_dut8 (
        .clk27m(clk), .rst(rst), .en(en8),
        .led_out(led8), .duty(duty8), .cycle_done(done8)
    );

    typedef struct {
        int         k;
        logic [3:0] duty;
        logic       done;
        logic       chk_led;
        logic       led;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        en8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cyc, t, ndone, bad, maxd, done_at, hit5;
        int done_cyc[3];
        logic [3:0] prev;

        vt[0]  = '{0,   4'd0,  1'b0, 1'b1, 1'b0};
        vt[1]  = '{3,   4'd0,  1'b0, 1'b0, 1'b0};
        vt[2]  = '{4,   4'd1,  1'b0, 1'b0, 1'b0};
        vt[3]  = '{23,  4'd5,  1'b0, 1'b0, 1'b0};
        vt[4]  = '{24,  4'd6,  1'b0, 1'b0, 1'b0};
        vt[5]  = '{59,  4'd14, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{60,  4'd15, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{67,  4'd15, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{71,  4'd15, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{72,  4'd14, 1'b0, 1'b0, 1'b0};
        vt[10] = '{127, 4'd1,  1'b0, 1'b0, 1'b0};
        vt[11] = '{128, 4'd0,  1'b0, 1'b0, 1'b0};
        vt[12] = '{135, 4'd0,  1'b0, 1'b1, 1'b0};
        vt[13] = '{136, 4'd0,  1'b1, 1'b1, 1'b0};
        vt[14] = '{137, 4'd0,  1'b0, 1'b1, 1'b0};
        vt[15] = '{200, 4'd0,  1'b0, 1'b1, 1'b0};

        // Reset mid-ramp
        repeat (3) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_duty", duty, 0);
        chk("rst_led", led, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (led || duty != 0 || done) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Single breath from an en pulse, table-driven
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        cyc = 0;
        ndone = (done) ? 1 : 0;
        for (int v = 0; v < 16; v++) begin
            while (cyc < vt[v].k) begin
                @(negedge clk);
                cyc++;
                if (done) ndone++;
            end
            chk($sformatf("tbl_duty_k%0d", vt[v].k), duty, vt[v].duty);
            chk($sformatf("tbl_done_k%0d", vt[v].k), done, vt[v].done);
            if (vt[v].chk_led) chk($sformatf("tbl_led_k%0d", vt[v].k), led, vt[v].led);
        end
        chk("single_done_count", ndone, 1);

        // PWM ratio in HOLD_HI / HOLD_LO with HOLD_STEPS=8
        en8 = 1'b1;
        @(negedge clk);
        en8 = 1'b0;
        t = 0;
        while (duty8 != 4'd15 && t < 100) begin @(negedge clk); t++; end
        chk("hold8_reach_max", (t < 100) ? 1 : 0, 1);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (led8) bad++;
        end
`ifdef GAMMA_EN
        chk("hold_hi_led_high", bad, 28);
`else
        chk("hold_hi_led_high", bad, 30);
`endif
        t = 0;
        while (duty8 != 4'd0 && t < 100) begin @(negedge clk); t++; end
        chk("hold8_reach_zero", (t < 100) ? 1 : 0, 1);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (led8) bad++;
        end
        chk("hold_lo_led_high", bad, 0);

        // en dropped during RAMP_UP at duty=5
        do_reset();
        en = 1'b1;
        @(negedge clk);
        cyc = 0; ndone = 0; maxd = 0; done_at = -1; hit5 = -1; bad = 0;
        while (cyc < 300) begin
            if (duty == 4'd5 && hit5 < 0) begin
                hit5 = cyc;
                en   = 1'b0;
            end
            if (int'(duty) > maxd) maxd = int'(duty);
            if (done) begin ndone++; done_at = cyc; end
            if (cyc > 136 && duty != 0) bad++;
            @(negedge clk);
            cyc++;
        end
        chk("drop_hit5_cycle", hit5, 20);
        chk("drop_max_duty", maxd, 15);
        chk("drop_done_count", ndone, 1);
        chk("drop_done_cycle", done_at, 136);
        chk("drop_no_restart", bad, 0);

        // en held for three breaths
        do_reset();
        en = 1'b1;
        @(negedge clk);
        cyc = 0; ndone = 0; bad = 0; prev = duty;
        done_cyc[0] = -1; done_cyc[1] = -1; done_cyc[2] = -1;
        while (cyc < 420) begin
            if (done) begin
                if (ndone < 3) done_cyc[ndone] = cyc;
                ndone++;
            end
            if (int'(duty) - int'(prev) > 1 || int'(prev) - int'(duty) > 1) bad++;
            prev = duty;
            @(negedge clk);
            cyc++;
        end
        en = 1'b0;
        chk("run3_done_count", ndone, 3);
        chk("run3_done0", done_cyc[0], 136);
        chk("run3_done1", done_cyc[1], 272);
        chk("run3_done2", done_cyc[2], 408);
        chk("run3_step_jumps", bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
